// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared constants and types for the 11011 sync-pattern family: the default
// sync pattern, the bit-stuff trigger that precedes a would-be sync match,
// the frame transmitter state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package seq_pkg;

  // Default sync pattern, transmitted MSB-first.
  localparam int                   SYNC_LEN     = 5;
  localparam logic [SYNC_LEN-1:0]  SYNC_PATTERN = 5'b11011;

  // Line history depth and the history value after which a 1 would complete
  // the sync pattern. A 0 is forced onto the line when the history matches.
  localparam int                   HIST_W       = 4;
  localparam logic [HIST_W-1:0]    STUFF_TRIG   = 4'b1101;

  // Transmitter phase. The state names describe what is on the line.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_DATA  = 2'b10,
    ST_GUARD = 2'b11
  } state_t;

  // Recovery target for an unexpected state value.
  localparam state_t STATE_DEFAULT = ST_IDLE;

  // Width of a counter that must hold values 0..n (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_stuff_ctrl.sv
// -----------------------------------------------------------------------------
// bit_stuff_ctrl
// Keeps the last HIST_W bits driven onto the serial line and flags when the
// next line bit must be a stuffed 0 so the sync pattern cannot form.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears the history)
//   bit_in     bit being placed on the line at the next clock edge
//   valid_in   bit_in is a real line bit (sync, payload or stuffed)
//   clear      empty the history (frame boundary); wins over valid_in
//   stuff_now  history currently equals STUFF_TRIG
// -----------------------------------------------------------------------------
module bit_stuff_ctrl
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic valid_in,
  input  logic clear,
  output logic stuff_now
);

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (valid_in) begin
      hist_d = {hist_q[HIST_W-2:0], bit_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // hist_q includes the bit currently on the line, so this decides the
  // next line bit.
  assign stuff_now = (hist_q == STUFF_TRIG);

endmodule

// File: rtl/sync_frame_tx.sv
// -----------------------------------------------------------------------------
// sync_frame_tx
// Serial frame transmitter. On an accepted start it sends the sync pattern
// MSB-first, then the captured payload MSB-first with bit stuffing so the
// sync pattern never reappears inside the frame, then GUARD_BITS idle zeros.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset, aborts any frame
//   start       frame request, only sampled while ready=1
//   data_in     payload, captured on the accepted start
//   ready       high while idle
//   tx_out      registered serial line
//   tx_valid    high while a sync, payload or stuffed bit is on tx_out
//   sync_phase  high while a sync bit is on tx_out
//   done        one-cycle pulse with the last payload bit on tx_out
// -----------------------------------------------------------------------------
module sync_frame_tx
  import seq_pkg::*;
#(
  parameter int                 DATA_W     = 8,
  parameter int                 SYNC_W     = SYNC_LEN,
  parameter logic [SYNC_W-1:0]  SYNC       = SYNC_PATTERN,
  parameter int                 GUARD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              tx_out,
  output logic              tx_valid,
  output logic              sync_phase,
  output logic              done
);

  localparam int CW = cnt_width(DATA_W);
  localparam int SW = cnt_width(SYNC_W);
  localparam int GW = cnt_width(GUARD_BITS);

  // state_q names the phase of the bit currently on tx_out; the comb block
  // decides the next line bit and the registers present it after the edge.
  state_t             state_q,     state_d;
  logic [DATA_W-1:0]  shreg_q,     shreg_d;
  logic [SYNC_W-1:0]  sync_sr_q,   sync_sr_d;
  logic [SW-1:0]      sync_cnt_q,  sync_cnt_d;
  logic [CW-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [GW-1:0]      guard_cnt_q, guard_cnt_d;
  logic               tx_q,        tx_d;
  logic               valid_q,     valid_d;
  logic               sphase_q,    sphase_d;
  logic               done_q,      done_d;
  logic               ready_q,     ready_d;

  logic               emit_data;
  logic               stuff_now;
  logic               hist_clear;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sync_sr_d   = sync_sr_q;
    sync_cnt_d  = sync_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    guard_cnt_d = guard_cnt_q;
    tx_d        = 1'b0;
    valid_d     = 1'b0;
    sphase_d    = 1'b0;
    done_d      = 1'b0;
    emit_data   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SYNC;
          shreg_d     = data_in;
          tx_d        = SYNC[SYNC_W-1];
          sync_sr_d   = SYNC << 1;
          sync_cnt_d  = SW'(1);
          bit_cnt_d   = '0;
          guard_cnt_d = '0;
          valid_d     = 1'b1;
          sphase_d    = 1'b1;
        end
      end

      ST_SYNC: begin
        if (sync_cnt_q != SW'(SYNC_W)) begin
          tx_d       = sync_sr_q[SYNC_W-1];
          sync_sr_d  = sync_sr_q << 1;
          sync_cnt_d = sync_cnt_q + 1'b1;
          valid_d    = 1'b1;
          sphase_d   = 1'b1;
        end else begin
          // Last sync bit is on the line; the next bit is payload (or stuff).
          state_d   = ST_DATA;
          emit_data = 1'b1;
        end
      end

      ST_DATA: begin
        emit_data = 1'b1;
      end

      ST_GUARD: begin
        if (guard_cnt_q != GW'(GUARD_BITS)) begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = STATE_DEFAULT;
      end
    endcase

    if (emit_data) begin
      if (bit_cnt_q == CW'(DATA_W)) begin
        // The last payload bit is on the line. Stuffing is only decided ahead
        // of a payload bit, so a frame never ends with a stuffed bit.
        if (GUARD_BITS > 0) begin
          state_d     = ST_GUARD;
          guard_cnt_d = GW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end else if (stuff_now) begin
        // Forced 0; the payload bit waits for the next cycle.
        tx_d    = 1'b0;
        valid_d = 1'b1;
      end else begin
        tx_d      = shreg_q[DATA_W-1];
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        valid_d   = 1'b1;
        done_d    = (bit_cnt_q == CW'(DATA_W - 1));
      end
    end
  end

  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    // History restarts with every frame, so the sync/payload overlap is seen
    // only against bits of the same frame.
    hist_clear = (state_d == ST_IDLE);
  end

  bit_stuff_ctrl u_stuff (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (tx_d),
    .valid_in  (valid_d),
    .clear     (hist_clear),
    .stuff_now (stuff_now)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      sync_sr_q   <= '0;
      sync_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      tx_q        <= 1'b0;
      valid_q     <= 1'b0;
      sphase_q    <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sync_sr_q   <= sync_sr_d;
      sync_cnt_q  <= sync_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      tx_q        <= tx_d;
      valid_q     <= valid_d;
      sphase_q    <= sphase_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign tx_out     = tx_q;
  assign tx_valid   = valid_q;
  assign sync_phase = sphase_q;
  assign done       = done_q;

endmodule
